ex_mem_stage: RTL and testbench
===============================

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 Single clock domain; reset asynchronous, active-high, named reset.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  async active-high reset.
REQ-004 Flush  input  1  discard all held entries; synchronous.
REQ-005 InValid  input  1  EX-side bundle valid.
REQ-006 InReady  output  1  stage can accept a bundle this cycle.
REQ-007 ALUResult  input  32  ALU result.
REQ-008 Zero  input  1  ALU zero flag.
REQ-009 Funct3  input  3  instruction funct3.
REQ-010 Branch  input  1  instruction is a conditional branch.
REQ-011 RegWrite  input  1  writes rd.
REQ-012 MemWrite  input  1  store.
REQ-013 Rd  input  5  destination register.
REQ-014 WriteData  input  32  store data (rs2).
REQ-015 PCTarget  input  32  branch target.
REQ-016 OutValid  output  1  MEM-side bundle valid.
REQ-017 OutReady  input  1  MEM side accepts this cycle.
REQ-018 ALUResultM, WriteDataM, PCTargetM  output  32 each  held copies.
REQ-019 RdM  output  5; RegWriteM, MemWriteM, TakenM  output  1 each  held copies / branch decision.

Function
REQ-020 Storage: two entries, MAIN (drives outputs) and SKID; each holds all captured fields plus Taken.
REQ-021 Taken computed at capture: Branch & (Funct3 in {000,001,100,101,110,111}) & (Zero ^ Funct3[0] ^ Funct3[2]); Funct3 010/011 with Branch -> Taken=0.
REQ-022 Branch encoding: BEQ/BNE use subtract (Zero = equal); BLT/BGE use slt, BLTU/BGEU use sltu (Zero = not-less).
REQ-023 States: EMPTY (no entry), ONE (MAIN valid), FULL (MAIN+SKID valid); OutValid = state!=EMPTY.
REQ-024 InReady = (state!=FULL), registered-state derived only; no combinational path from OutReady to InReady.
REQ-025 Transfer in = InValid & InReady; transfer out = OutValid & OutReady.
REQ-026 EMPTY: in -> load MAIN, go ONE.
REQ-027 ONE: in only -> load SKID, go FULL; out only -> EMPTY; in+out -> load MAIN, stay ONE.
REQ-028 FULL: out -> SKID moves to MAIN, go ONE; no out -> hold.
REQ-029 Latency: bundle accepted in cycle N appears on outputs in N+1 when stage was EMPTY or ONE-with-out.
REQ-030 Order strictly FIFO; no bundle dropped or duplicated absent Flush.
REQ-031 Output fields stable while OutValid & ~OutReady.
REQ-032 Flush: next state EMPTY, overrides any simultaneous in/out; bundle presented that cycle is discarded.
REQ-033 Entry data registers need no reset; only valid/state and TakenM, RegWriteM, MemWriteM are reset.
REQ-034 When OutValid=0, RegWriteM=MemWriteM=TakenM=0.

Reset
REQ-035 reset asserted: immediately state EMPTY, OutValid=0, InReady=0 during reset, RegWriteM=MemWriteM=TakenM=0.
REQ-036 After reset deasserts, InReady=1 from the first clock edge onward; reset mid-transfer discards all entries.

Verification
REQ-037 BEQ, ALUResult=0, Zero=1, Funct3=000, OutReady=1 -> next cycle OutValid=1, TakenM=1, PCTargetM = input target.
REQ-038 BGEU via sltu, Zero=0, Funct3=111 -> TakenM=0; same with Funct3=010 and Zero=1 -> TakenM=0.
REQ-039 OutReady=0, three back-to-back InValid bundles A,B,C -> A,B accepted, InReady=0 on C; release OutReady -> A,B,C emerge in order, none lost.
REQ-040 FULL with OutReady=1 and InValid=1 same cycle -> MAIN<-SKID, new bundle into SKID the following cycle; order preserved.
REQ-041 Flush asserted while FULL with InValid=1 -> next cycle OutValid=0, RegWriteM=0, MemWriteM=0, InReady=1.
REQ-042 reset pulse asynchronous mid-cycle while ONE -> OutValid and RegWriteM fall before next clock edge.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with a two-entry skid buffer (MAIN drives outputs, SKID catches overflow).
// InReady comes from registered state only, so OutReady never reaches InReady combinationally.
module ex_mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        Flush,
    input  logic        InValid,
    output logic        InReady,
    input  logic [31:0] ALUResult,
    input  logic        Zero,
    input  logic [2:0]  Funct3,
    input  logic        Branch,
    input  logic        RegWrite,
    input  logic        MemWrite,
    input  logic [4:0]  Rd,
    input  logic [31:0] WriteData,
    input  logic [31:0] PCTarget,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [31:0] ALUResultM,
    output logic [31:0] WriteDataM,
    output logic [31:0] PCTargetM,
    output logic [4:0]  RdM,
    output logic        RegWriteM,
    output logic        MemWriteM,
    output logic        TakenM
);

    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] ONE   = 2'b01;
    localparam logic [1:0] FULL  = 2'b10;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [31:0] pct;
        logic [4:0]  rd;
    } data_t;

    typedef struct packed {
        logic rw;
        logic mw;
        logic taken;
    } ctl_t;

    logic [1:0] state_q, state_d;
    data_t      main_data_q, main_data_d;
    data_t      skid_data_q, skid_data_d;
    ctl_t       main_ctl_q, main_ctl_d;
    ctl_t       skid_ctl_q, skid_ctl_d;

    data_t      in_data;
    ctl_t       in_ctl;
    logic       in_fire;
    logic       out_fire;

    // Zero means "equal" for BEQ/BNE and "not less" for the slt/sltu branches;
    // funct3[0] and funct3[2] together fold the per-branch inversion into one xor.
    assign in_ctl.taken = Branch & (Funct3[2:1] != 2'b01) & (Zero ^ Funct3[0] ^ Funct3[2]);
    assign in_ctl.rw    = RegWrite;
    assign in_ctl.mw    = MemWrite;
    assign in_data.alu   = ALUResult;
    assign in_data.wdata = WriteData;
    assign in_data.pct   = PCTarget;
    assign in_data.rd    = Rd;

    assign OutValid = (state_q != EMPTY);
    assign InReady  = ~reset & (state_q != FULL);
    assign in_fire  = InValid & InReady;
    assign out_fire = OutValid & OutReady;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctl_d  = main_ctl_q;
        skid_data_d = skid_data_q;
        skid_ctl_d  = skid_ctl_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_data_d = in_data;
                    main_ctl_d  = in_ctl;
                    state_d     = ONE;
                end
            end
            ONE: begin
                if (in_fire && !out_fire) begin
                    skid_data_d = in_data;
                    skid_ctl_d  = in_ctl;
                    state_d     = FULL;
                end else if (in_fire && out_fire) begin
                    main_data_d = in_data;
                    main_ctl_d  = in_ctl;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    main_data_d = skid_data_q;
                    main_ctl_d  = skid_ctl_q;
                    state_d     = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (Flush) begin
            state_d    = EMPTY;
            main_ctl_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= EMPTY;
            main_ctl_q <= '0;
        end else begin
            state_q    <= state_d;
            main_ctl_q <= main_ctl_d;
        end
    end

    // Payload registers carry no reset; they are only observed while OutValid is set.
    always_ff @(posedge clk) begin
        main_data_q <= main_data_d;
        skid_data_q <= skid_data_d;
        skid_ctl_q  <= skid_ctl_d;
    end

    assign ALUResultM = main_data_q.alu;
    assign WriteDataM = main_data_q.wdata;
    assign PCTargetM  = main_data_q.pct;
    assign RdM        = main_data_q.rd;
    assign RegWriteM  = OutValid & main_ctl_q.rw;
    assign MemWriteM  = OutValid & main_ctl_q.mw;
    assign TakenM     = OutValid & main_ctl_q.taken;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed vector table, async reset pulse, then random traffic vs a queue model.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        Flush, InValid, InReady;
    logic [31:0] ALUResult, WriteData, PCTarget;
    logic        Zero, Branch, RegWrite, MemWrite;
    logic [2:0]  Funct3;
    logic [4:0]  Rd;
    logic        OutValid, OutReady;
    logic [31:0] ALUResultM, WriteDataM, PCTargetM;
    logic [4:0]  RdM;
    logic        RegWriteM, MemWriteM, TakenM;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ex_mem_stage dut (
        .clk(clk), .reset(reset), .Flush(Flush),
        .InValid(InValid), .InReady(InReady),
        .ALUResult(ALUResult), .Zero(Zero), .Funct3(Funct3), .Branch(Branch),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .Rd(Rd),
        .WriteData(WriteData), .PCTarget(PCTarget),
        .OutValid(OutValid), .OutReady(OutReady),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCTargetM(PCTargetM),
        .RdM(RdM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .TakenM(TakenM)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Directed vectors: inputs for one cycle, then the expected outputs after that edge.
    typedef struct {
        logic       flush, vld, ordy, zero, br, rw, mw;
        logic [2:0] f3;
        logic [4:0] rd;
        logic       e_vld, e_rdy, e_tk, e_rw, e_mw;
        logic [4:0] e_rd;
    } vec_t;

    vec_t tbl[19];

    // Architectural branch outcome from the ISA meaning of each funct3.
    function automatic logic ref_taken(input logic br, input logic [2:0] f3, input logic z);
        if (!br) return 1'b0;
        case (f3)
            3'b000: return z;    // BEQ
            3'b001: return !z;   // BNE
            3'b100: return !z;   // BLT: zero means not-less
            3'b101: return z;    // BGE
            3'b110: return !z;   // BLTU
            3'b111: return z;    // BGEU
            default: return 1'b0;
        endcase
    endfunction

    typedef struct {
        logic [31:0] alu, wd, pct;
        logic [4:0]  rd;
        logic        rw, mw, tk;
    } item_t;

    item_t q[$];

    task automatic drive_row(input vec_t v);
        Flush     = v.flush;
        InValid   = v.vld;
        OutReady  = v.ordy;
        Zero      = v.zero;
        Branch    = v.br;
        RegWrite  = v.rw;
        MemWrite  = v.mw;
        Funct3    = v.f3;
        Rd        = v.rd;
        ALUResult = 32'(v.rd) * 3;
        WriteData = 32'hBEEF0000 | 32'(v.rd);
        PCTarget  = 32'h1000 + 32'(v.rd) * 4;
    endtask

    initial begin
        reset = 1'b1;
        Flush = 0; InValid = 0; OutReady = 0; Zero = 0; Branch = 0;
        RegWrite = 0; MemWrite = 0; Funct3 = 0; Rd = 0;
        ALUResult = 0; WriteData = 0; PCTarget = 0;

        //       fl vl or z  br rw mw f3      rd   | vld rdy tk rw mw rd
        tbl[0]  = '{0, 1, 1, 1, 1, 0, 0, 3'b000, 5'd1,  1, 1, 1, 0, 0, 5'd1};
        tbl[1]  = '{0, 0, 1, 0, 0, 0, 0, 3'b000, 5'd0,  0, 1, 0, 0, 0, 5'd0};
        tbl[2]  = '{0, 1, 1, 0, 1, 0, 0, 3'b111, 5'd2,  1, 1, 0, 0, 0, 5'd2};
        tbl[3]  = '{0, 1, 1, 1, 1, 0, 0, 3'b010, 5'd3,  1, 1, 0, 0, 0, 5'd3};
        tbl[4]  = '{0, 0, 1, 0, 0, 0, 0, 3'b000, 5'd0,  0, 1, 0, 0, 0, 5'd0};
        tbl[5]  = '{0, 1, 0, 0, 0, 1, 0, 3'b000, 5'd4,  1, 1, 0, 1, 0, 5'd4};
        tbl[6]  = '{0, 1, 0, 0, 0, 0, 0, 3'b000, 5'd5,  1, 0, 0, 1, 0, 5'd4};
        tbl[7]  = '{0, 1, 0, 0, 0, 0, 0, 3'b000, 5'd6,  1, 0, 0, 1, 0, 5'd4};
        tbl[8]  = '{0, 1, 1, 0, 0, 0, 0, 3'b000, 5'd6,  1, 1, 0, 0, 0, 5'd5};
        tbl[9]  = '{0, 1, 1, 0, 0, 0, 0, 3'b000, 5'd6,  1, 1, 0, 0, 0, 5'd6};
        tbl[10] = '{0, 0, 1, 0, 0, 0, 0, 3'b000, 5'd0,  0, 1, 0, 0, 0, 5'd0};
        tbl[11] = '{0, 1, 0, 0, 0, 1, 1, 3'b000, 5'd7,  1, 1, 0, 1, 1, 5'd7};
        tbl[12] = '{0, 1, 0, 0, 0, 0, 0, 3'b000, 5'd8,  1, 0, 0, 1, 1, 5'd7};
        tbl[13] = '{1, 1, 0, 0, 0, 1, 1, 3'b000, 5'd9,  0, 1, 0, 0, 0, 5'd0};
        tbl[14] = '{0, 1, 0, 1, 1, 0, 0, 3'b001, 5'd9,  1, 1, 0, 0, 0, 5'd9};
        tbl[15] = '{0, 1, 0, 0, 1, 0, 0, 3'b001, 5'd10, 1, 0, 0, 0, 0, 5'd9};
        tbl[16] = '{0, 1, 1, 0, 0, 0, 0, 3'b000, 5'd11, 1, 1, 1, 0, 0, 5'd10};
        tbl[17] = '{0, 1, 1, 0, 1, 0, 0, 3'b100, 5'd11, 1, 1, 1, 0, 0, 5'd11};
        tbl[18] = '{0, 0, 1, 0, 0, 0, 0, 3'b000, 5'd0,  0, 1, 0, 0, 0, 5'd0};

        // Reset state
        #12;
        chk("rst_outvalid", 32'(OutValid), 32'd0);
        chk("rst_inready",  32'(InReady),  32'd0);
        chk("rst_regwrite", 32'(RegWriteM), 32'd0);
        chk("rst_memwrite", 32'(MemWriteM), 32'd0);
        chk("rst_taken",    32'(TakenM),    32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_inready", 32'(InReady), 32'd1);

        for (int i = 0; i < 19; i++) begin
            drive_row(tbl[i]);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_outvalid", i), 32'(OutValid), 32'(tbl[i].e_vld));
            chk($sformatf("v%0d_inready", i),  32'(InReady),  32'(tbl[i].e_rdy));
            chk($sformatf("v%0d_taken", i),    32'(TakenM),   32'(tbl[i].e_tk));
            chk($sformatf("v%0d_regwrite", i), 32'(RegWriteM), 32'(tbl[i].e_rw));
            chk($sformatf("v%0d_memwrite", i), 32'(MemWriteM), 32'(tbl[i].e_mw));
            if (tbl[i].e_vld) begin
                chk($sformatf("v%0d_rd", i),  32'(RdM), 32'(tbl[i].e_rd));
                chk($sformatf("v%0d_pct", i), PCTargetM, 32'h1000 + 32'(tbl[i].e_rd) * 4);
                chk($sformatf("v%0d_alu", i), ALUResultM, 32'(tbl[i].e_rd) * 3);
            end
        end

        // Async reset pulse while one entry is held
        InValid = 1; OutReady = 0; RegWrite = 1; Rd = 5'd20; Flush = 0;
        @(posedge clk);
        #1 InValid = 0;
        @(negedge clk);
        chk("pre_areset_outvalid", 32'(OutValid), 32'd1);
        chk("pre_areset_regwrite", 32'(RegWriteM), 32'd1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("areset_outvalid", 32'(OutValid), 32'd0);
        chk("areset_regwrite", 32'(RegWriteM), 32'd0);
        chk("areset_inready",  32'(InReady),   32'd0);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("after_areset_inready",  32'(InReady),  32'd1);
        chk("after_areset_outvalid", 32'(OutValid), 32'd0);

        // Random traffic against a queue model of capacity two
        q.delete();
        for (int c = 0; c < 600; c++) begin
            bit    exp_vld, exp_rdy, inf, outf;
            item_t it;
            exp_vld = (q.size() > 0);
            exp_rdy = (q.size() < 2);
            chk("rnd_outvalid", 32'(OutValid), 32'(exp_vld));
            chk("rnd_inready",  32'(InReady),  32'(exp_rdy));
            if (exp_vld) begin
                chk("rnd_alu",   ALUResultM, q[0].alu);
                chk("rnd_wd",    WriteDataM, q[0].wd);
                chk("rnd_pct",   PCTargetM,  q[0].pct);
                chk("rnd_rd",    32'(RdM),       32'(q[0].rd));
                chk("rnd_rw",    32'(RegWriteM), 32'(q[0].rw));
                chk("rnd_mw",    32'(MemWriteM), 32'(q[0].mw));
                chk("rnd_taken", 32'(TakenM),    32'(q[0].tk));
            end else begin
                chk("rnd_idle_flags", {29'd0, RegWriteM, MemWriteM, TakenM}, 32'd0);
            end

            Flush     = ($urandom_range(0, 19) == 0);
            InValid   = ($urandom_range(0, 3) != 0);
            OutReady  = ($urandom_range(0, 2) != 0);
            Zero      = 1'($urandom);
            Branch    = 1'($urandom);
            RegWrite  = 1'($urandom);
            MemWrite  = 1'($urandom);
            Funct3    = 3'($urandom);
            Rd        = 5'($urandom);
            ALUResult = $urandom;
            WriteData = $urandom;
            PCTarget  = $urandom;

            inf  = InValid && (q.size() < 2);
            outf = OutReady && (q.size() > 0);
            if (Flush) begin
                q.delete();
            end else begin
                if (outf) void'(q.pop_front());
                if (inf) begin
                    it.alu = ALUResult; it.wd = WriteData; it.pct = PCTarget;
                    it.rd  = Rd; it.rw = RegWrite; it.mw = MemWrite;
                    it.tk  = ref_taken(Branch, Funct3, Zero);
                    q.push_back(it);
                end
            end
            @(posedge clk);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
